rle_enc_str: RTL and testbench



---
 rtl/rle_enc_str.sv | 193 +++++++++++++++++++
 tb/tb_rle_enc_str.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_enc_str.sv
// Run-length encoder with valid/ready on both streams and an FD-word output FIFO.
// Optional statistics counters are enabled by defining RLE_STAT_EN.
module rle_enc_str #(
  parameter int DW = 32,
  parameter int KW = DW / 8,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef RLE_STAT_EN
  input  logic          clr_stat,
  output logic [31:0]   stat_in,
  output logic [31:0]   stat_out,
`endif
  input  logic          enable,
  input  logic          flush,
  input  logic [KW-1:0] disabledGroups,
  input  logic [DW-1:0] sti_data,
  input  logic          sti_valid,
  output logic          sti_ready,
  output logic [DW-1:0] sto_data,
  output logic          sto_valid,
  input  logic          sto_ready
);

  localparam int AW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);
  localparam logic [DW-2:0] RMAX = '1;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t        r_state;
  logic [DW-1:0] r_val;
  logic [DW-2:0] r_run;
  logic          r_flushPend;
  logic [DW-1:0] r_mem [FD];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  state_t        w_st;
  state_t        w_nState;
  logic [DW-1:0] w_nVal;
  logic [DW-2:0] w_nRun;
  logic          w_nPend;
  logic [DW-1:0] w_m;
  logic [DW-1:0] w_mRle;
  logic [DW-2:0] w_runInc;
  logic          w_accept;
  logic          w_pop;
  logic          w_hasRoom;
  logic          w_pushCnt;
  logic [DW-1:0] w_cntWord;
  logic          w_pushVal;
  logic [DW-1:0] w_valWord;
  logic [AW-1:0] w_valIdx;

  always_comb begin
    w_m = sti_data;
    for (int g = 0; g < KW; g++) begin
      if (disabledGroups[g]) w_m[g*8 +: 8] = 8'h00;
    end
  end

  assign w_mRle    = {1'b0, w_m[DW-2:0]};
  assign w_runInc  = r_run + (DW-1)'(1);
  assign sti_ready = ~rst & (r_cnt <= CW'(FD - 2));
  assign w_accept  = sti_valid & sti_ready;
  assign sto_valid = (r_cnt != '0);
  assign sto_data  = r_mem[r_rd];
  assign w_pop     = sto_valid & sto_ready;
  assign w_hasRoom = (r_cnt < CW'(FD));
  assign w_valIdx  = r_wr + AW'(w_pushCnt);

  // At most one count word and one value word per cycle, count always first.
  // A held or implicit flush closes the old run before this cycle's sample.
  always_comb begin
    w_st      = r_state;
    w_nState  = r_state;
    w_nVal    = r_val;
    w_nRun    = r_run;
    w_nPend   = r_flushPend;
    w_pushCnt = 1'b0;
    w_cntWord = {1'b1, r_run};
    w_pushVal = 1'b0;
    w_valWord = w_mRle;

    if (r_flushPend || (r_state == RUN && !enable)) begin
      if (r_state == RUN && r_run != '0) begin
        if (w_hasRoom) begin
          w_pushCnt = 1'b1;
          w_st      = IDLE;
          w_nRun    = '0;
          w_nPend   = 1'b0;
        end else begin
          w_nPend = 1'b1;
        end
      end else begin
        w_st    = IDLE;
        w_nPend = 1'b0;
      end
    end

    if (w_accept) begin
      if (!enable) begin
        w_pushVal = 1'b1;
        w_valWord = w_m;
        w_nState  = IDLE;
      end else if (w_st == IDLE || w_mRle != r_val) begin
        if (w_st == RUN && r_run != '0) w_pushCnt = 1'b1;
        w_pushVal = 1'b1;
        w_nVal    = w_mRle;
        w_nRun    = '0;
        w_nState  = flush ? IDLE : RUN;
      end else if (r_run == RMAX) begin
        w_pushCnt = 1'b1;
        w_pushVal = 1'b1;
        w_nRun    = '0;
        w_nState  = flush ? IDLE : RUN;
      end else if (flush) begin
        w_pushCnt = 1'b1;
        w_cntWord = {1'b1, w_runInc};
        w_nRun    = '0;
        w_nState  = IDLE;
      end else begin
        w_nRun   = w_runInc;
        w_nState = RUN;
      end
    end else if (flush) begin
      if (w_st == RUN && r_run != '0) begin
        if (w_hasRoom) begin
          w_pushCnt = 1'b1;
          w_nRun    = '0;
          w_nState  = IDLE;
        end else begin
          w_nPend  = 1'b1;
          w_nState = w_st;
        end
      end else begin
        w_nRun   = '0;
        w_nState = IDLE;
      end
    end else begin
      w_nState = w_st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_val       <= '0;
      r_run       <= '0;
      r_flushPend <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < FD; i++) r_mem[i] <= '0;
    end else begin
      r_state     <= w_nState;
      r_val       <= w_nVal;
      r_run       <= w_nRun;
      r_flushPend <= w_nPend;
      if (w_pushCnt) r_mem[r_wr] <= w_cntWord;
      if (w_pushVal) r_mem[w_valIdx] <= w_valWord;
      r_wr  <= r_wr + AW'(w_pushCnt) + AW'(w_pushVal);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_pushCnt) + CW'(w_pushVal) - CW'(w_pop);
    end
  end

`ifdef RLE_STAT_EN
  logic [31:0] r_statIn;
  logic [31:0] r_statOut;

  // A transfer coinciding with clr_stat restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_statIn  <= '0;
      r_statOut <= '0;
    end else if (clr_stat) begin
      r_statIn  <= 32'(w_accept);
      r_statOut <= 32'(w_pop);
    end else begin
      r_statIn  <= r_statIn + 32'(w_accept);
      r_statOut <= r_statOut + 32'(w_pop);
    end
  end

  assign stat_in  = r_statIn;
  assign stat_out = r_statOut;
`endif

endmodule

// File: tb/tb_rle_enc_str.sv
// Directed bench for rle_enc_str: a DW=32 instance driven from a vector table
// plus hand sequences, and a DW=8 instance for counter saturation.
module tb_rle_enc_str;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [3:0]  dg;
  logic [31:0] sti_data;
  logic        sti_valid;
  logic        sti_ready;
  logic [31:0] sto_data;
  logic        sto_valid;
  logic        sto_ready;

  logic        en8;
  logic        flush8;
  logic [0:0]  dg8;
  logic [7:0]  d8;
  logic        v8;
  logic        ready8;
  logic [7:0]  o8;
  logic        ov8;
  logic        or8;

  int total = 0;
  int bad   = 0;
  logic [31:0] gotQ[$];
  logic [31:0] expQ[$];
  logic [7:0]  got8[$];

  always #5 clk = ~clk;

`ifdef RLE_STAT_EN
  logic        clrStat = 1'b0;
  logic [31:0] statIn, statOut, statIn8, statOut8;
`endif

  rle_enc_str #(.DW(32), .FD(4)) dut (
    .clk(clk), .rst(rst),
`ifdef RLE_STAT_EN
    .clr_stat(clrStat), .stat_in(statIn), .stat_out(statOut),
`endif
    .enable(enable), .flush(flush), .disabledGroups(dg),
    .sti_data(sti_data), .sti_valid(sti_valid), .sti_ready(sti_ready),
    .sto_data(sto_data), .sto_valid(sto_valid), .sto_ready(sto_ready)
  );

  rle_enc_str #(.DW(8), .FD(4)) dut8 (
    .clk(clk), .rst(rst),
`ifdef RLE_STAT_EN
    .clr_stat(clrStat), .stat_in(statIn8), .stat_out(statOut8),
`endif
    .enable(en8), .flush(flush8), .disabledGroups(dg8),
    .sti_data(d8), .sti_valid(v8), .sti_ready(ready8),
    .sto_data(o8), .sto_valid(ov8), .sto_ready(or8)
  );

  // Capture every output transfer; the edge following this negedge performs it.
  always @(negedge clk) begin
    if (!rst && sto_valid && sto_ready) gotQ.push_back(sto_data);
    if (!rst && ov8 && or8) got8.push_back(o8);
  end

  typedef struct {
    logic        en;
    logic [3:0]  dg;
    logic [31:0] data;
    logic        vld;
    logic        fl;
    int          nExp;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        chkNow;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(input logic en, input logic [3:0] g, input logic [31:0] d,
                                 input logic vld, input logic fl, input int n,
                                 input logic [31:0] e0, input logic [31:0] e1, input logic chk);
    vec_t v;
    v.en = en; v.dg = g; v.data = d; v.vld = vld; v.fl = fl;
    v.nExp = n; v.e0 = e0; v.e1 = e1; v.chkNow = chk;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    enable    = v.en;
    dg        = v.dg;
    sti_data  = v.data;
    sti_valid = v.vld;
    n = 0;
    @(negedge clk);
    if (v.vld) begin
      while (!sti_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!sti_ready) begin
        total++;
        bad++;
        $display("[TB] FAIL accept_timeout actual=not_ready required=ready data=%h", v.data);
      end
    end
    flush = v.fl;
    @(posedge clk);
    #1;
    sti_valid = 1'b0;
    flush     = 1'b0;
    if (v.nExp > 0) expQ.push_back(v.e0);
    if (v.nExp > 1) expQ.push_back(v.e1);
    if (v.chkNow) begin
      checkOutput("latency_valid", {31'b0, sto_valid}, 32'd1);
      checkOutput("latency_data", sto_data, v.e0);
    end
  endtask

  task automatic applyStim8(input logic [7:0] d, input logic fl);
    int n;
    d8 = d;
    v8 = 1'b1;
    n  = 0;
    @(negedge clk);
    while (!ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) begin
      total++;
      bad++;
      $display("[TB] FAIL accept8_timeout actual=not_ready required=ready data=%h", d);
    end
    flush8 = fl;
    @(posedge clk);
    #1;
    v8     = 1'b0;
    flush8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        seenReady;
    logic [7:0]  exp8 [5];

    rst = 1'b1; enable = 1'b0; flush = 1'b0; dg = 4'b0000;
    sti_data = '0; sti_valid = 1'b0; sto_ready = 1'b1;
    en8 = 1'b1; flush8 = 1'b0; dg8 = 1'b0; d8 = '0; v8 = 1'b0; or8 = 1'b1;

    // Bypass stream, RLE with group masking, MSB handling, flush variants.
    tbl.push_back(mkVec(0, 4'b0000, 32'h00000000, 1, 0, 1, 32'h00000000, 0, 1));
    tbl.push_back(mkVec(0, 4'b0000, 32'h01010101, 1, 0, 1, 32'h01010101, 0, 1));
    tbl.push_back(mkVec(0, 4'b0000, 32'h02020202, 1, 0, 1, 32'h02020202, 0, 1));
    tbl.push_back(mkVec(0, 4'b0000, 32'h03030303, 1, 0, 1, 32'h03030303, 0, 1));
    tbl.push_back(mkVec(1, 4'b1110, 32'h11223341, 1, 0, 1, 32'h00000041, 0, 0));
    tbl.push_back(mkVec(1, 4'b1110, 32'h00000042, 1, 0, 1, 32'h00000042, 0, 0));
    tbl.push_back(mkVec(1, 4'b1110, 32'h00000042, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b1110, 32'h00000042, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b1110, 32'h00000043, 1, 0, 2, 32'h80000002, 32'h00000043, 0));
    tbl.push_back(mkVec(1, 4'b1110, 32'h00000000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'hFFFFFFFF, 1, 0, 1, 32'h7FFFFFFF, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000000, 0, 1, 1, 32'h80000001, 0, 0));
    tbl.push_back(mkVec(0, 4'b0000, 32'hFFFFFFFF, 1, 0, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mkVec(0, 4'b0000, 32'hFFFFFFFF, 1, 0, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000005, 1, 0, 1, 32'h00000005, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000005, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000005, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 4'b0000, 32'h00000009, 1, 0, 2, 32'h80000002, 32'h00000009, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h0000000A, 1, 0, 1, 32'h0000000A, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h0000000A, 1, 1, 1, 32'h80000001, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h0000000A, 1, 0, 1, 32'h0000000A, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h0000000B, 1, 1, 1, 32'h0000000B, 0, 0));
    tbl.push_back(mkVec(0, 4'b0101, 32'hAABBCCDD, 1, 0, 1, 32'hAA00CC00, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h80000005, 1, 0, 1, 32'h00000005, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000005, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(1, 4'b0000, 32'h00000000, 0, 1, 1, 32'h80000001, 0, 0));

    idle(3);
    checkOutput("rst_sto_valid", {31'b0, sto_valid}, 32'd0);
    checkOutput("rst_sto_data", sto_data, 32'd0);
    checkOutput("rst_sti_ready", {31'b0, sti_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_sti_ready", {31'b0, sti_ready}, 32'd1);
    idle(1);

    $display("[TB] table vectors: %0d", tbl.size());
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);
    idle(6);

    // Backpressure: three queued words must block the input.
    $display("[TB] backpressure sequence");
    sto_ready = 1'b0;
    applyStimulus(mkVec(1, 4'b0000, 32'h1, 1, 0, 1, 32'h1, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h2, 1, 0, 1, 32'h2, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h1, 1, 0, 1, 32'h1, 0, 0));
    checkOutput("bp_ready_low", {31'b0, sti_ready}, 32'd0);
    checkOutput("bp_head_valid", {31'b0, sto_valid}, 32'd1);
    checkOutput("bp_head_data", sto_data, 32'h1);
    sti_data  = 32'h2;
    sti_valid = 1'b1;
    seenReady = 1'b0;
    repeat (17) begin
      @(negedge clk);
      if (sti_ready) seenReady = 1'b1;
    end
    checkOutput("bp_ready_held", {31'b0, seenReady}, 32'd0);
    sto_ready = 1'b1;
    applyStimulus(mkVec(1, 4'b0000, 32'h2, 1, 0, 1, 32'h2, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h1, 1, 0, 1, 32'h1, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h2, 1, 0, 1, 32'h2, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h0, 0, 1, 0, 0, 0, 0));
    idle(6);

    // Reset in the middle of a run of 0x7 with five repeats.
    $display("[TB] reset mid-run sequence");
    applyStimulus(mkVec(1, 4'b0000, 32'h7, 1, 0, 1, 32'h7, 0, 0));
    for (int i = 0; i < 5; i++) applyStimulus(mkVec(1, 4'b0000, 32'h7, 1, 0, 0, 0, 0, 0));
    idle(4);
    rst = 1'b1;
    idle(1);
    checkOutput("midrst_sto_valid", {31'b0, sto_valid}, 32'd0);
    checkOutput("midrst_sti_ready", {31'b0, sti_ready}, 32'd0);
    rst = 1'b0;
    idle(1);
    applyStimulus(mkVec(1, 4'b0000, 32'h7, 1, 0, 1, 32'h7, 0, 0));
    applyStimulus(mkVec(1, 4'b0000, 32'h0, 0, 1, 0, 0, 0, 0));
    idle(6);

    // Counter saturation on the 8-bit instance.
    $display("[TB] saturation sequence");
    for (int i = 0; i < 130; i++) applyStim8(8'h05, 1'b0);
    applyStim8(8'h06, 1'b0);
    d8 = 8'h00;
    @(negedge clk);
    flush8 = 1'b1;
    idle(1);
    flush8 = 1'b0;
    idle(8);

    checkOutput("stream_len", gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < gotQ.size()) checkOutput($sformatf("stream[%0d]", i), gotQ[i], expQ[i]);
    end

    exp8[0] = 8'h05; exp8[1] = 8'hFF; exp8[2] = 8'h05; exp8[3] = 8'h81; exp8[4] = 8'h06;
    checkOutput("stream8_len", got8.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got8.size()) checkOutput($sformatf("stream8[%0d]", i), {24'b0, got8[i]}, {24'b0, exp8[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
